// File: rtl/max7219_frame_scheduler_pkg.sv
// Shared definitions for the MAX7219 frame scheduler.
//  - MAX7219 register addresses used by the scheduler
//  - power-up init word table (init_word)
//  - scheduler state encoding and packet-issuer state encoding
package max7219_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int INIT_LEN = 5;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_INTENS = 2'd2,
    S_FRAME  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_ISSUE = 2'd1,
    P_WAIT  = 2'd2,
    P_GAP   = 2'd3
  } pkt_state_t;

  // Power-up sequence: display on, BCD decode on all digits, scan 6 digits,
  // reset intensity, display test off.
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] inten);
    case (idx)
      4'd0:    init_word = {REG_SHUTDOWN, 8'h01};
      4'd1:    init_word = {REG_DECODE, 8'hFF};
      4'd2:    init_word = {REG_SCANLIM, 8'h05};
      4'd3:    init_word = {REG_INTENSITY, 4'h0, inten};
      default: init_word = {REG_TEST, 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/max7219_frame_scheduler_if.sv
// SPI_Master command interface between the scheduler (master) and the
// SPI_Master block (slave).
//  spi_word  : {addr, data} word to shift out
//  spi_cs_n  : low starts/holds a packet
//  spi_ready : SPI_Master idle and able to accept a packet
//  spi_sent  : SPI_Master finished shifting the current word
// Handshake: the master drops spi_cs_n only while spi_ready=1 and keeps
// spi_word stable for as long as spi_cs_n=0; spi_sent=1 ends the packet and
// the master raises spi_cs_n on the following edge.
interface max7219_frame_scheduler_if;
  logic [15:0] spi_word;
  logic        spi_cs_n;
  logic        spi_ready;
  logic        spi_sent;

  modport master (output spi_word, output spi_cs_n, input spi_ready, input spi_sent);
  modport slave  (input spi_word, input spi_cs_n, output spi_ready, output spi_sent);
endinterface

// File: rtl/max7219_frame_scheduler_spi_pkt_issuer.sv
// Single-packet issuer: ISSUE -> WAIT_SENT -> GAP.
//  clk, rst_n : clock, async active-low reset
//  req, word  : one-cycle request with the word to send (accepted in P_IDLE)
//  done       : one-cycle pulse when the trailing gap has elapsed
//  aborted    : valid with done; the packet ended by timeout
//  timeout    : one-cycle pulse at the moment a packet is abandoned
//  pkt_state  : current packet state (debug)
//  spi        : SPI_Master command interface
module spi_pkt_issuer
  import max7219_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] word,
  output logic        done,
  output logic        aborted,
  output logic        timeout,
  output pkt_state_t  pkt_state,
  max7219_frame_scheduler_if.master spi
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   word_q;
  logic          abort_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state    <= P_IDLE;
      spi.spi_cs_n <= 1'b1;
      spi.spi_word <= '0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      word_q       <= '0;
      abort_q      <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      timeout <= 1'b0;
      case (pkt_state)
        P_IDLE: begin
          if (req) begin
            word_q    <= word;
            pkt_state <= P_ISSUE;
          end
        end
        P_ISSUE: begin
          if (spi.spi_ready) begin
            spi.spi_word <= word_q;
            spi.spi_cs_n <= 1'b0;
            tmo_cnt      <= '0;
            abort_q      <= 1'b0;
            pkt_state    <= P_WAIT;
          end
        end
        P_WAIT: begin
          // tmo_cnt holds the number of edges already spent with cs_n low,
          // so cs_n rises exactly TIMEOUT_CYCLES cycles after it fell.
          if (spi.spi_sent) begin
            spi.spi_cs_n <= 1'b1;
            gap_cnt      <= '0;
            pkt_state    <= P_GAP;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            spi.spi_cs_n <= 1'b1;
            timeout      <= 1'b1;
            abort_q      <= 1'b1;
            gap_cnt      <= '0;
            pkt_state    <= P_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        P_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            done      <= 1'b1;
            aborted   <= abort_q;
            pkt_state <= P_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: pkt_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/max7219_frame_scheduler.sv
// MAX7219 frame scheduler: arbitrates the SPI_Master between the power-up
// init list, pending intensity writes and digit frames.
//  clk, rst_n     : clock, async active-low reset
//  tick           : frame request strobe
//  disp_ena       : frames allowed when 1
//  digits,dp_mask : BCD digits and decimal points, snapshotted at frame start
//  intensity(_wr) : brightness value and its write strobe
//  spi            : SPI_Master command interface (master side)
//  init_done      : init list completed
//  busy           : packet/frame in progress or work pending
//  overrun_cnt    : saturating count of dropped ticks
//  timeout_err    : sticky packet timeout flag
//  state_dbg, pkt_state_dbg : scheduler and packet states (debug)
module max7219_frame_scheduler
  import max7219_pkg::*;
#(
  parameter int         NUM_DIGITS     = 6,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [3:0] INTENSITY_RST  = 4'h8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    disp_ena,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [3:0]              intensity,
  input  logic                    intensity_wr,
  max7219_frame_scheduler_if.master spi,
  output logic                    init_done,
  output logic                    busy,
  output logic [7:0]              overrun_cnt,
  output logic                    timeout_err,
  output sched_state_t            state_dbg,
  output pkt_state_t              pkt_state_dbg
);

  sched_state_t            state;
  logic [3:0]              idx;
  logic                    pkt_active;
  logic                    pkt_req;
  logic [15:0]             pkt_req_word;
  logic                    pkt_done;
  logic                    pkt_aborted;
  logic                    pkt_timeout;
  logic                    frame_pend;
  logic                    int_pend;
  logic [3:0]              int_val;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic        frame_trig;
  logic        idle_free;
  logic        take_pend;
  logic        take_tick;
  logic [3:0]  cur_digit;
  logic        cur_dp;
  logic [15:0] next_word;

  assign state_dbg  = state;
  assign frame_trig = tick & disp_ena & init_done;
  assign idle_free  = (state == S_IDLE) && !int_pend;
  // A queued frame is taken first; a fresh tick only starts a frame directly
  // when nothing else is queued or arriving, so a same-cycle intensity write wins.
  assign take_pend  = idle_free && frame_pend && disp_ena;
  assign take_tick  = idle_free && !frame_pend && frame_trig && !intensity_wr;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 4'(i)) begin
        cur_digit = snap_digits[4*i +: 4];
        cur_dp    = snap_dp[i];
      end
    end
    next_word = '0;
    case (state)
      S_INIT:  next_word = init_word(idx, INTENSITY_RST);
      S_FRAME: next_word = {REG_DIGIT0 + {4'h0, idx}, cur_dp, 3'b000, cur_digit};
      default: next_word = {REG_INTENSITY, 4'h0, int_val};
    endcase
  end

  spi_pkt_issuer #(
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_issuer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (pkt_req),
    .word     (pkt_req_word),
    .done     (pkt_done),
    .aborted  (pkt_aborted),
    .timeout  (pkt_timeout),
    .pkt_state(pkt_state_dbg),
    .spi      (spi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      idx          <= '0;
      pkt_active   <= 1'b0;
      pkt_req      <= 1'b0;
      pkt_req_word <= '0;
      frame_pend   <= 1'b0;
      int_pend     <= 1'b0;
      int_val      <= '0;
      snap_digits  <= '0;
      snap_dp      <= '0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      pkt_req <= 1'b0;
      busy    <= (state != S_IDLE) || int_pend || frame_pend;
      if (pkt_timeout) timeout_err <= 1'b1;
      if (pkt_done) pkt_active <= 1'b0;

      case (state)
        S_INIT: begin
          if (!pkt_active) begin
            pkt_req      <= 1'b1;
            pkt_req_word <= next_word;
            pkt_active   <= 1'b1;
          end else if (pkt_done) begin
            if (pkt_aborted) begin
              idx <= '0;
            end else if (idx == 4'(INIT_LEN - 1)) begin
              idx       <= '0;
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_IDLE: begin
          if (int_pend) begin
            pkt_req      <= 1'b1;
            pkt_req_word <= {REG_INTENSITY, 4'h0, int_val};
            pkt_active   <= 1'b1;
            int_pend     <= 1'b0;
            state        <= S_INTENS;
          end else if (take_pend || take_tick) begin
            snap_digits <= digits;
            snap_dp     <= dp_mask;
            idx         <= '0;
            state       <= S_FRAME;
          end
        end
        S_INTENS: begin
          if (pkt_done) state <= S_IDLE;
        end
        S_FRAME: begin
          if (!pkt_active) begin
            pkt_req      <= 1'b1;
            pkt_req_word <= next_word;
            pkt_active   <= 1'b1;
          end else if (pkt_done) begin
            if (pkt_aborted || idx == 4'(NUM_DIGITS - 1)) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= S_INIT;
      endcase

      // Written after the IDLE branch so a write in the consuming cycle re-arms.
      if (intensity_wr) begin
        int_pend <= 1'b1;
        int_val  <= intensity;
      end

      // One-deep frame queue; a tick that finds it still full is dropped.
      if (frame_trig && !take_tick) begin
        if (frame_pend && !take_pend) begin
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end else begin
          frame_pend <= 1'b1;
        end
      end else if (take_pend) begin
        frame_pend <= 1'b0;
      end
      if (!disp_ena) frame_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Testbench for max7219_frame_scheduler: model SPI_Master, expected-word
// scoreboard checked on every packet start, directed scenarios.
module tb_max7219_frame_scheduler;
  import max7219_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic         disp_ena;
  logic [23:0]  digits;
  logic [5:0]   dp_mask;
  logic [3:0]   intensity;
  logic         intensity_wr;
  logic         init_done;
  logic         busy;
  logic [7:0]   overrun_cnt;
  logic         timeout_err;
  sched_state_t state_dbg;
  pkt_state_t   pkt_state_dbg;

  max7219_frame_scheduler_if spi_bus ();

  max7219_frame_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .disp_ena     (disp_ena),
    .digits       (digits),
    .dp_mask      (dp_mask),
    .intensity    (intensity),
    .intensity_wr (intensity_wr),
    .spi          (spi_bus),
    .init_done    (init_done),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg),
    .pkt_state_dbg(pkt_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pkt_seen = 0;
  int          lo_cnt   = 0;
  int          hi_cnt   = 0;
  int          last_lo  = 0;
  bit          have_prev = 0;
  bit          mute      = 0;
  logic        prev_cs   = 1'b1;
  logic [15:0] cur_word  = '0;
  logic [15:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule for one digit packet: address i+1, dp in data[7], BCD in data[3:0].
  function automatic logic [15:0] frame_word(input int i, input logic [23:0] d, input logic [5:0] dp);
    return {8'(i + 1), dp[i], 3'b000, d[4*i +: 4]};
  endfunction

  task automatic push_frame(input logic [23:0] d, input logic [5:0] dp);
    for (int i = 0; i < 6; i++) exp_q.push_back(frame_word(i, d, dp));
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0B05);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0F00);
  endtask

  // ---------------- model SPI_Master ----------------
  initial begin
    spi_bus.spi_ready = 1'b1;
    spi_bus.spi_sent  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !spi_bus.spi_cs_n) begin
        spi_bus.spi_ready = 1'b0;
        for (int k = 0; k < 65; k++) begin
          @(negedge clk);
          if (!rst_n || spi_bus.spi_cs_n) break;
        end
        if (rst_n && !spi_bus.spi_cs_n && !mute) begin
          spi_bus.spi_sent = 1'b1;
          @(negedge clk);
          spi_bus.spi_sent = 1'b0;
        end
        for (int k = 0; k < 400 && rst_n && !spi_bus.spi_cs_n; k++) @(negedge clk);
        @(negedge clk);
        spi_bus.spi_ready = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs   = 1'b1;
        have_prev = 0;
        lo_cnt    = 0;
        hi_cnt    = 0;
      end else begin
        if (!spi_bus.spi_cs_n) begin
          if (prev_cs) begin
            if (have_prev) check("cs_gap_ge4", 32'(hi_cnt >= 4), 32'd1);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_packet: got 0x%04h with no word expected at %0t", spi_bus.spi_word, $time);
            end else begin
              exp_w = exp_q.pop_front();
              check("packet_word", 32'(spi_bus.spi_word), 32'(exp_w));
            end
            cur_word  = spi_bus.spi_word;
            pkt_seen++;
            lo_cnt    = 0;
            have_prev = 1;
          end else begin
            check("word_stable", 32'(spi_bus.spi_word), 32'(cur_word));
          end
          lo_cnt++;
          hi_cnt = 0;
        end else begin
          if (!prev_cs) last_lo = lo_cnt;
          hi_cnt++;
        end
        prev_cs = spi_bus.spi_cs_n;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic pulse_intensity(input logic [3:0] v);
    @(negedge clk);
    intensity    = v;
    intensity_wr = 1'b1;
    @(negedge clk) intensity_wr = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int stable = 0;
    int n = 0;
    while (stable < 10 && n < budget) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !busy && spi_bus.spi_cs_n) stable++;
      else stable = 0;
    end
    if (stable < 10) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles, %0d words outstanding", name, n, exp_q.size());
    end
  endtask

  task automatic wait_pkts(input string name, input int target, input int budget);
    int n = 0;
    while (pkt_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pkt_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: saw %0d packets, required %0d", name, pkt_seen, target);
    end
  endtask

  task automatic wait_cs(input string name, input logic level, input int budget);
    int n = 0;
    while (spi_bus.spi_cs_n !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (spi_bus.spi_cs_n !== level) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: cs_n=%b after %0d cycles, required %b", name, spi_bus.spi_cs_n, n, level);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n        = 1'b0;
    tick         = 1'b0;
    disp_ena     = 1'b1;
    digits       = '0;
    dp_mask      = '0;
    intensity    = '0;
    intensity_wr = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_bus.spi_cs_n), 32'd1);
    check("rst_word", 32'(spi_bus.spi_word), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Init list; a tick during init is ignored, an intensity write waits
    push_init();
    exp_q.push_back(16'h0A03);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pulse_tick();
    pulse_intensity(4'h3);
    wait_quiet("init", 3000);
    check("init_done", 32'(init_done), 32'd1);
    check("init_overrun", 32'(overrun_cnt), 32'd0);
    check("init_timeout_err", 32'(timeout_err), 32'd0);

    // Frame 59:59:99 with dp on digits 2 and 4; digits change mid-frame
    digits  = 24'h595999;
    dp_mask = 6'b010100;
    exp_q.push_back(16'h0109);
    exp_q.push_back(16'h0209);
    exp_q.push_back(16'h0389);
    exp_q.push_back(16'h0405);
    exp_q.push_back(16'h0589);
    exp_q.push_back(16'h0605);
    base = pkt_seen;
    pulse_tick();
    wait_pkts("frame1_start", base + 2, 500);
    digits  = 24'h123456;
    dp_mask = 6'b000000;
    wait_quiet("frame1", 1500);
    check("frame1_overrun", 32'(overrun_cnt), 32'd0);
    check("frame1_busy", 32'(busy), 32'd0);

    // Three ticks during one frame: one queued frame, two overruns
    digits  = 24'h012345;
    dp_mask = 6'b000011;
    push_frame(digits, dp_mask);
    push_frame(digits, dp_mask);
    pulse_tick();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      repeat (10) @(negedge clk);
    end
    wait_quiet("overrun3", 3000);
    check("overrun_2", 32'(overrun_cnt), 32'd2);

    // 300 more ticks during one frame: counter saturates
    push_frame(digits, dp_mask);
    push_frame(digits, dp_mask);
    pulse_tick();
    repeat (5) @(negedge clk);
    tick = 1'b1;
    repeat (300) @(negedge clk);
    tick = 1'b0;
    wait_quiet("overrun300", 3000);
    check("overrun_sat", 32'(overrun_cnt), 32'd255);

    // Intensity write and tick in the same cycle: intensity goes first
    digits  = 24'h908070;
    dp_mask = 6'b100001;
    exp_q.push_back(16'h0A0F);
    push_frame(digits, dp_mask);
    @(negedge clk);
    tick         = 1'b1;
    intensity    = 4'hF;
    intensity_wr = 1'b1;
    @(negedge clk);
    tick         = 1'b0;
    intensity_wr = 1'b0;
    wait_quiet("intens_tick", 2000);
    check("intens_tick_busy", 32'(busy), 32'd0);

    // disp_ena falling mid-frame drops the queued frame
    digits  = 24'h111111;
    dp_mask = 6'b000000;
    push_frame(digits, dp_mask);
    base = pkt_seen;
    pulse_tick();
    wait_pkts("dispena_start", base + 1, 500);
    pulse_tick();
    repeat (5) @(negedge clk);
    disp_ena = 1'b0;
    pulse_tick();
    wait_quiet("dispena", 1500);
    repeat (200) @(negedge clk);
    check("dispena_no_extra", 32'(exp_q.size()), 32'd0);
    check("dispena_busy", 32'(busy), 32'd0);
    disp_ena = 1'b1;

    // Master never reports sent: timeout after 255 cycles, back to idle
    mute = 1;
    exp_q.push_back(frame_word(0, digits, dp_mask));
    pulse_tick();
    wait_cs("tmo_low", 1'b0, 100);
    wait_cs("tmo_high", 1'b1, 400);
    @(negedge clk);
    check("tmo_low_len", 32'(last_lo), 32'd255);
    check("tmo_err", 32'(timeout_err), 32'd1);
    wait_quiet("tmo", 300);
    check("tmo_state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    mute = 0;

    // Reset pulse in the middle of a packet clears everything
    exp_q.push_back(frame_word(0, digits, dp_mask));
    pulse_tick();
    wait_cs("rst_mid_low", 1'b0, 100);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(spi_bus.spi_cs_n), 32'd1);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    check("midrst_overrun", 32'(overrun_cnt), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_q_empty", 32'(exp_q.size()), 32'd0);
    push_init();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_quiet("reinit", 3000);
    check("reinit_done", 32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
